// File: rtl/regfile_scoreboard_pkg.sv
// Shared definitions for the register-file scoreboard: default sizing and the
// issue descriptor bundled from the issue-port signals.
package regfile_scoreboard_pkg;

  localparam int unsigned DEFAULT_NUM_REGS        = 32;
  localparam int unsigned DEFAULT_MAX_PENDING     = 3;
  localparam int unsigned DEFAULT_MAX_INFLIGHT    = 8;
  localparam bit          DEFAULT_COMPLETE_BYPASS = 1'b1;

  // Fixed-width index field so the struct does not depend on NUM_REGS
  localparam int unsigned SB_IDX_W = 8;

  typedef struct packed {
    logic                we;
    logic [SB_IDX_W-1:0] rd;
    logic [SB_IDX_W-1:0] rs1;
    logic [SB_IDX_W-1:0] rs2;
    logic                uses_rs1;
    logic                uses_rs2;
  } sb_issue_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Issue / complete / kill bundle plus scoreboard status, shared between the
// scoreboard (slave) and whoever drives the pipeline (master).
interface regfile_scoreboard_if import regfile_scoreboard_pkg::*; #(
  parameter int unsigned NUM_REGS     = DEFAULT_NUM_REGS,
  parameter int unsigned MAX_INFLIGHT = DEFAULT_MAX_INFLIGHT
);
  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned IW    = $clog2(MAX_INFLIGHT + 1);

  logic             issue_valid_i;
  logic [IDX_W-1:0] issue_rd_i;
  logic [IDX_W-1:0] issue_rs1_i;
  logic [IDX_W-1:0] issue_rs2_i;
  logic             issue_we_i;
  logic             issue_uses_rs1_i;
  logic             issue_uses_rs2_i;
  logic             issue_stall_o;
  logic             complete_valid_i;
  logic [IDX_W-1:0] complete_rd_i;
  logic             kill_valid_i;
  logic [IDX_W-1:0] kill_rd_i;
  logic [NUM_REGS-1:0] busy_o;
  logic [IW-1:0]    inflight_o;
  logic             err_o;

  modport master (
    output issue_valid_i, issue_rd_i, issue_rs1_i, issue_rs2_i, issue_we_i,
           issue_uses_rs1_i, issue_uses_rs2_i, complete_valid_i, complete_rd_i,
           kill_valid_i, kill_rd_i,
    input  issue_stall_o, busy_o, inflight_o, err_o
  );

  modport slave (
    input  issue_valid_i, issue_rd_i, issue_rs1_i, issue_rs2_i, issue_we_i,
           issue_uses_rs1_i, issue_uses_rs2_i, complete_valid_i, complete_rd_i,
           kill_valid_i, kill_rd_i,
    output issue_stall_o, busy_o, inflight_o, err_o
  );

endinterface

// File: rtl/scoreboard_counter.sv
// Pending-write counter for one architectural register. Applies the net of one
// increment and up to two decrements; a net result below zero clamps to zero.
module scoreboard_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             dec2_i,
  output logic [CNT_W-1:0] count_o,
  output logic             underflow_o,
  output logic [1:0]       deficit_o
);
  // Two spare bits: one for the +1 headroom, one as sign
  localparam int unsigned SW = CNT_W + 2;

  logic [CNT_W-1:0] count_q, count_d;
  logic [SW-1:0]    sum;

  always_comb begin
    sum         = SW'(count_q) + SW'(inc_i) - SW'(dec_i) - (SW'(dec2_i) << 1);
    underflow_o = sum[SW-1];
    // How much of the requested decrement could not be applied
    deficit_o   = underflow_o ? 2'(SW'(0) - sum) : 2'd0;
    count_d     = underflow_o ? '0 : CNT_W'(sum);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register-file scoreboard: tracks outstanding writes per register, stalls
// issue on RAW and capacity hazards, and flags completions with nothing pending.
module regfile_scoreboard import regfile_scoreboard_pkg::*; #(
  parameter int unsigned NUM_REGS        = DEFAULT_NUM_REGS,
  parameter int unsigned MAX_PENDING     = DEFAULT_MAX_PENDING,
  parameter int unsigned MAX_INFLIGHT    = DEFAULT_MAX_INFLIGHT,
  parameter bit          COMPLETE_BYPASS = DEFAULT_COMPLETE_BYPASS
) (
  input  logic           clk_i,
  input  logic           reset_i,
  regfile_scoreboard_if.slave sb
);
  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam int unsigned CW    = $clog2(MAX_PENDING + 1);
  localparam int unsigned IW    = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned DW    = IW + 2;

  sb_issue_t           iss;
  logic [IDX_W-1:0]    rd, rs1, rs2, crd, krd;
  logic [CW-1:0]       count   [NUM_REGS];
  logic [1:0]          deficit [NUM_REGS];
  logic [NUM_REGS-1:0] busy, underflow;
  logic [IW-1:0]       inflight_q, inflight_d;
  logic                err_q;
  logic                rd_hz, rs1_hz, rs2_hz, stall, accept;
  logic                c_live, k_live;
  logic [1:0]          n_dec, lost;

  always_comb begin
    iss.we       = sb.issue_we_i;
    iss.rd       = SB_IDX_W'(sb.issue_rd_i);
    iss.rs1      = SB_IDX_W'(sb.issue_rs1_i);
    iss.rs2      = SB_IDX_W'(sb.issue_rs2_i);
    iss.uses_rs1 = sb.issue_uses_rs1_i;
    iss.uses_rs2 = sb.issue_uses_rs2_i;
  end

  assign rd  = IDX_W'(iss.rd);
  assign rs1 = IDX_W'(iss.rs1);
  assign rs2 = IDX_W'(iss.rs2);
  assign crd = sb.complete_rd_i;
  assign krd = sb.kill_rd_i;

  // Events aimed at r0 are dropped here so they never reach a counter
  assign c_live = sb.complete_valid_i && (crd != '0);
  assign k_live = sb.kill_valid_i && (krd != '0);

  assign count[0]     = '0;
  assign deficit[0]   = '0;
  assign underflow[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    logic [1:0] ndec;
    logic       inc;

    assign ndec = 2'(c_live && (crd == IDX_W'(r))) + 2'(k_live && (krd == IDX_W'(r)));
    assign inc  = accept && (rd == IDX_W'(r));

    scoreboard_counter #(
      .CNT_W (CW)
    ) u_cnt (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .inc_i       (inc),
      .dec_i       (ndec == 2'd1),
      .dec2_i      (ndec == 2'd2),
      .count_o     (count[r]),
      .underflow_o (underflow[r]),
      .deficit_o   (deficit[r])
    );
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      busy[i] = (count[i] != '0);
    end
  end

  always_comb begin
    rd_hz  = iss.we && (rd != '0) &&
             ((count[rd] == CW'(MAX_PENDING)) || (inflight_q == IW'(MAX_INFLIGHT)));
    // A write retiring this cycle as the last one pending releases its readers
    rs1_hz = iss.uses_rs1 && busy[rs1] &&
             !(COMPLETE_BYPASS && sb.complete_valid_i && (crd == rs1) && (count[rs1] == CW'(1)));
    rs2_hz = iss.uses_rs2 && busy[rs2] &&
             !(COMPLETE_BYPASS && sb.complete_valid_i && (crd == rs2) && (count[rs2] == CW'(1)));
    stall  = sb.issue_valid_i && (rs1_hz || rs2_hz || rd_hz);
    accept = sb.issue_valid_i && !stall && iss.we && (rd != '0);
  end

  // Only the completed / killed registers can clamp, so their deficits give
  // back exactly the decrements that were not applied.
  always_comb begin
    n_dec      = 2'(c_live) + 2'(k_live);
    lost       = (crd == krd) ? deficit[crd] : deficit[crd] + deficit[krd];
    inflight_d = IW'(DW'(inflight_q) + DW'(accept) - DW'(n_dec) + DW'(lost));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_q | (|underflow);
    end
  end

  assign sb.issue_stall_o = stall;
  assign sb.busy_o        = busy;
  assign sb.inflight_o    = inflight_q;
  assign sb.err_o         = err_q;

endmodule
